// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sequencing two requesters onto one shared multiplier
module mult_arbiter #(
  parameter int OPCNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [31:0]        req0_a,
  input  logic [31:0]        req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [31:0]        req1_a,
  input  logic [31:0]        req1_b,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [31:0]        resp0_data,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [31:0]        resp1_data,
  output logic               mul_wstrb,
  output logic               mul_rstrb,
  output logic [1:0]         mul_sel,
  output logic [31:0]        mul_wdata,
  input  logic [31:0]        mul_rdata,
  output logic               busy,
  output logic [OPCNT_W-1:0] ops_done
);

  typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_GO, S_WAIT, S_READ, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant, owner;
  logic [31:0] op_a, op_b;
  logic        grant0, grant1, accept, resp_hs;

  // Port 1 only wins a contention when port 0 was served last, and vice versa.
  assign grant0  = req0_valid && (!req1_valid || last_grant);
  assign grant1  = req1_valid && (!req0_valid || !last_grant);
  assign accept  = (state_q == S_IDLE) && (grant0 || grant1);
  assign resp_hs = (state_q == S_RESP) && (owner ? resp1_ready : resp0_ready);

  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    mul_wstrb   = 1'b0;
    mul_rstrb   = 1'b0;
    mul_sel     = 2'b11;
    mul_wdata   = 32'd0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (accept) state_d = S_WR_A;
      end
      S_WR_A: begin
        mul_wstrb = 1'b1;
        mul_sel   = 2'b00;
        mul_wdata = op_a;
        state_d   = S_WR_B;
      end
      S_WR_B: begin
        mul_wstrb = 1'b1;
        mul_sel   = 2'b01;
        mul_wdata = op_b;
        state_d   = S_GO;
      end
      S_GO: begin
        mul_wstrb = 1'b1;
        mul_sel   = 2'b10;
        state_d   = S_WAIT;
      end
      S_WAIT: state_d = S_READ;
      S_READ: begin
        mul_rstrb = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
        if (resp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      resp0_data <= 32'd0;
      resp1_data <= 32'd0;
      ops_done   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        op_a       <= grant1 ? req1_a : req0_a;
        op_b       <= grant1 ? req1_b : req0_b;
      end
      if (state_q == S_READ) begin
        if (owner) resp1_data <= mul_rdata;
        else       resp0_data <= mul_rdata;
      end
      if (resp_hs) ops_done <= ops_done + OPCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;
  localparam int OPCNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, resp0_ready = 0, resp1_ready = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data, mul_wdata, mul_rdata;
  logic mul_wstrb, mul_rstrb, busy;
  logic [1:0] mul_sel;
  logic [OPCNT_W-1:0] ops_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.OPCNT_W(OPCNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .mul_wstrb(mul_wstrb), .mul_rstrb(mul_rstrb), .mul_sel(mul_sel),
    .mul_wdata(mul_wdata), .mul_rdata(mul_rdata), .busy(busy), .ops_done(ops_done)
  );

  // Behavioural multiplier peripheral: start arms on the GO write, result lands one edge later.
  logic [31:0] m_a, m_b, m_res;
  logic        m_start;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= 0; m_b <= 0; m_res <= 0; m_start <= 0;
    end else if (mul_wstrb) begin
      case (mul_sel)
        2'b00: m_a <= mul_wdata;
        2'b01: m_b <= mul_wdata;
        2'b10: m_start <= 1'b1;
        default: ;
      endcase
    end else if (m_start) begin
      m_res   <= m_a * m_b;
      m_start <= 1'b0;
    end
  end
  assign mul_rdata = (mul_sel == 2'b11) ? m_res : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p);
    int n;
    if (port == 0) begin req0_valid = 1; req0_a = a; req0_b = b; resp0_ready = 1; end
    else begin req1_valid = 1; req1_a = a; req1_b = b; resp1_ready = 1; end
    #1;
    n = 0;
    while (!(port == 0 ? req0_ready : req1_ready) && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n >= 20) $display("FAIL run_op accept port%0d: ready never seen", port);
    else pass_cnt++;
    tick();
    if (port == 0) req0_valid = 0; else req1_valid = 0;
    n = 1;
    while (!(port == 0 ? resp0_valid : resp1_valid) && n < 20) begin tick(); n++; end
    total_cnt++;
    if (n != 6) $display("FAIL run_op latency port%0d: got %0d want 6", port, n);
    else pass_cnt++;
    total_cnt++;
    if ((port == 0 ? resp0_data : resp1_data) !== exp_p)
      $display("FAIL run_op data port%0d: got %h want %h", port,
               (port == 0 ? resp0_data : resp1_data), exp_p);
    else pass_cnt++;
    tick();
    exp_ops = (exp_ops + 1) % 4;
    total_cnt++;
    if (ops_done !== OPCNT_W'(exp_ops))
      $display("FAIL run_op ops_done: got %0d want %0d", ops_done, exp_ops);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({busy, mul_wstrb, mul_rstrb, mul_sel, mul_wdata, resp0_valid, resp1_valid, ops_done}
        !== {1'b0, 1'b0, 1'b0, 2'b11, 32'd0, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset outputs: busy=%b wstrb=%b rstrb=%b sel=%b wdata=%h ops=%0d",
               busy, mul_wstrb, mul_rstrb, mul_sel, mul_wdata, ops_done);
    else pass_cnt++;
    total_cnt++;
    if ({resp0_data, resp1_data} !== 64'd0)
      $display("FAIL reset resp_data: got %h %h want 0", resp0_data, resp1_data);
    else pass_cnt++;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_sequence();
    req0_valid = 1; req0_a = 6; req0_b = 7; resp0_ready = 1;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL seq accept: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    tick(); req0_valid = 0; #1;
    total_cnt++;
    if ({busy, mul_wstrb, mul_sel, mul_wdata} !== {1'b1, 1'b1, 2'b00, 32'd6})
      $display("FAIL seq wr_a: got %b %b %b %h", busy, mul_wstrb, mul_sel, mul_wdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mul_wstrb, mul_sel, mul_wdata} !== {1'b1, 2'b01, 32'd7})
      $display("FAIL seq wr_b: got %b %b %h", mul_wstrb, mul_sel, mul_wdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mul_wstrb, mul_sel, mul_wdata} !== {1'b1, 2'b10, 32'd0})
      $display("FAIL seq go: got %b %b %h", mul_wstrb, mul_sel, mul_wdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mul_wstrb, mul_rstrb, mul_sel, resp0_valid} !== {1'b0, 1'b0, 2'b11, 1'b0})
      $display("FAIL seq wait: got %b %b %b %b", mul_wstrb, mul_rstrb, mul_sel, resp0_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mul_wstrb, mul_rstrb, mul_sel} !== {1'b0, 1'b1, 2'b11})
      $display("FAIL seq read: got %b %b %b", mul_wstrb, mul_rstrb, mul_sel);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({resp0_valid, resp1_valid, resp0_data, ops_done} !== {1'b1, 1'b0, 32'd42, 2'd0})
      $display("FAIL seq resp: got v=%b%b data=%0d ops=%0d", resp0_valid, resp1_valid,
               resp0_data, ops_done);
    else pass_cnt++;
    tick();
    exp_ops = 1;
    total_cnt++;
    if ({busy, resp0_valid, ops_done} !== {1'b0, 1'b0, 2'd1})
      $display("FAIL seq done: got busy=%b v=%b ops=%0d", busy, resp0_valid, ops_done);
    else pass_cnt++;
  endtask

  task automatic test_port1_wrap();
    run_op(1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_op(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
  endtask

  task automatic test_dual();
    req0_valid = 1; req0_a = 3; req0_b = 5; resp0_ready = 1;
    req1_valid = 1; req1_a = 4; req1_b = 9; resp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL dual grant %0d: got %b", k, {req0_ready, req1_ready});
      else pass_cnt++;
      for (int c = 0; c < 6; c++) begin
        tick();
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b00)
          $display("FAIL dual ready while busy %0d/%0d: got %b", k, c, {req0_ready, req1_ready});
        else pass_cnt++;
      end
      total_cnt++;
      if (k % 2 == 0) begin
        if ({resp0_valid, resp1_valid, resp0_data} !== {2'b10, 32'd15})
          $display("FAIL dual resp %0d: got v=%b%b d=%0d want port0 15", k, resp0_valid,
                   resp1_valid, resp0_data);
        else pass_cnt++;
      end else begin
        if ({resp0_valid, resp1_valid, resp1_data} !== {2'b01, 32'd36})
          $display("FAIL dual resp %0d: got v=%b%b d=%0d want port1 36", k, resp0_valid,
                   resp1_valid, resp1_data);
        else pass_cnt++;
      end
      tick();
      exp_ops = (exp_ops + 1) % 4;
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    total_cnt++;
    if (ops_done !== OPCNT_W'(exp_ops))
      $display("FAIL dual ops_done: got %0d want %0d", ops_done, exp_ops);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    req0_valid = 1; req0_a = 2; req0_b = 3; resp0_ready = 0;
    req1_valid = 1; req1_a = 1; req1_b = 1; resp1_ready = 1;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL stall accept: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    tick(); req0_valid = 0;
    repeat (5) tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++;
      if ({resp0_valid, resp0_data, req1_ready} !== {1'b1, 32'd6, 1'b0})
        $display("FAIL stall hold %0d: got v=%b d=%0d r1=%b", c, resp0_valid, resp0_data, req1_ready);
      else pass_cnt++;
      tick();
    end
    resp0_ready = 1;
    #1;
    total_cnt++;
    if ({resp0_valid, req1_ready} !== 2'b10)
      $display("FAIL stall handshake: got v=%b r1=%b", resp0_valid, req1_ready);
    else pass_cnt++;
    tick();
    exp_ops = (exp_ops + 1) % 4;
    total_cnt++;
    if ({req1_ready, resp0_valid} !== 2'b10)
      $display("FAIL stall port1 accept: got r1=%b v0=%b", req1_ready, resp0_valid);
    else pass_cnt++;
    tick(); req1_valid = 0;
    repeat (5) tick();
    total_cnt++;
    if ({resp1_valid, resp1_data} !== {1'b1, 32'd1})
      $display("FAIL stall port1 resp: got v=%b d=%0d", resp1_valid, resp1_data);
    else pass_cnt++;
    tick();
    exp_ops = (exp_ops + 1) % 4;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req0_a = 9; req0_b = 9; resp0_ready = 1;
    #1;
    tick(); req0_valid = 0;
    repeat (3) tick();
    total_cnt++;
    if ({busy, mul_wstrb, mul_sel} !== {1'b1, 1'b0, 2'b11})
      $display("FAIL rstmid in wait: got busy=%b wstrb=%b sel=%b", busy, mul_wstrb, mul_sel);
    else pass_cnt++;
    rst = 1;
    #1;
    total_cnt++;
    if ({busy, mul_wstrb, mul_rstrb, mul_sel, resp0_valid, resp1_valid, ops_done, req0_ready}
        !== {1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0})
      $display("FAIL rstmid outputs: busy=%b sel=%b v=%b%b ops=%0d", busy, mul_sel,
               resp0_valid, resp1_valid, ops_done);
    else pass_cnt++;
    exp_ops = 0;
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total_cnt++;
      if ({busy, resp0_valid, resp1_valid} !== 3'b000)
        $display("FAIL rstmid no response %0d: busy=%b v=%b%b", c, busy, resp0_valid, resp1_valid);
      else pass_cnt++;
    end
    run_op(0, 32'd9, 32'd9, 32'd81);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1; tick(); rst = 0; tick();
    req0_valid = 1; resp0_ready = 1;
    for (int k = 0; k < 5; k++) begin
      req0_a = k + 2; req0_b = 10;
      #1;
      total_cnt++;
      if (req0_ready !== 1'b1) $display("FAIL b2b accept %0d: got %b want 1", k, req0_ready);
      else pass_cnt++;
      repeat (6) tick();
      total_cnt++;
      if ({resp0_valid, resp0_data} !== {1'b1, 32'((k + 2) * 10)})
        $display("FAIL b2b resp %0d: got v=%b d=%0d want %0d", k, resp0_valid, resp0_data, (k + 2) * 10);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ops_done !== exp_seq[k])
        $display("FAIL b2b ops_done %0d: got %0d want %0d", k, ops_done, exp_seq[k]);
      else pass_cnt++;
    end
    req0_valid = 0;
  endtask

  initial begin
    tick();
    test_reset();
    test_sequence();
    test_port1_wrap();
    test_dual();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
